// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves MEM-stage loads/stores and IF-stage fetches
// over a single 8-bit synchronous RAM port, data port first, never preempted.
module mem_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_data_i,
    input  logic [2:0]  ram_length,
    input  logic        ram_signed,
    output logic        ram_ready,
    output logic [31:0] ram_data_o,
    input  logic        if_read,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [31:0] addr_q;
    logic [2:0]  len_q;
    logic        sgn_q;
    logic        fetch_q;
    logic [31:0] data_q;
    logic [31:0] rbuf;
    logic [2:0]  len_norm;
    logic [1:0]  cap_idx;
    logic [31:0] ext;

    // Illegal lengths collapse to a full word.
    assign len_norm = (ram_length == 3'd1) ? 3'd1 :
                      (ram_length == 3'd2) ? 3'd2 : 3'd4;

    // Byte arriving now was addressed one cycle earlier, i.e. at cnt-1.
    assign cap_idx = cnt[1:0] - 2'd1;

    always_comb begin
        case (len_q)
            3'd1:    ext = {{24{sgn_q & rbuf[7]}}, rbuf[7:0]};
            3'd2:    ext = {{16{sgn_q & rbuf[15]}}, rbuf[15:0]};
            default: ext = rbuf;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        mem_a      = 32'd0;
        mem_wr     = 1'b0;
        mem_dout   = 8'd0;
        ram_ready  = 1'b0;
        ram_data_o = 32'd0;
        if_ready   = 1'b0;
        if_data    = 32'd0;
        case (state)
            IDLE: begin
                if (ram_read)       state_nx = RD;
                else if (ram_write) state_nx = WR;
                else if (if_read)   state_nx = RD;
            end
            RD: begin
                if (cnt < {5'd0, len_q})
                    mem_a = addr_q + {24'd0, cnt};
                if (fetch_q && !if_read)
                    state_nx = IDLE;
                else if (cnt == {5'd0, len_q})
                    state_nx = DONE;
            end
            WR: begin
                mem_a    = addr_q + {24'd0, cnt};
                mem_wr   = 1'b1;
                mem_dout = data_q[{cnt[1:0], 3'b000} +: 8];
                if (cnt == {5'd0, len_q} - 8'd1)
                    state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
                if (fetch_q) begin
                    if_ready = 1'b1;
                    if_data  = ext;
                end else begin
                    ram_ready  = 1'b1;
                    ram_data_o = ext;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 8'd0;
            addr_q  <= 32'd0;
            len_q   <= 3'd0;
            sgn_q   <= 1'b0;
            fetch_q <= 1'b0;
            data_q  <= 32'd0;
            rbuf    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (ram_read) begin
                        addr_q  <= ram_addr;
                        len_q   <= len_norm;
                        sgn_q   <= ram_signed;
                        fetch_q <= 1'b0;
                        rbuf    <= 32'd0;
                    end else if (ram_write) begin
                        addr_q  <= ram_addr;
                        len_q   <= len_norm;
                        data_q  <= ram_data_i;
                        fetch_q <= 1'b0;
                    end else if (if_read) begin
                        addr_q  <= if_addr;
                        len_q   <= 3'd4;
                        sgn_q   <= 1'b0;
                        fetch_q <= 1'b1;
                        rbuf    <= 32'd0;
                    end
                end
                RD: begin
                    cnt <= cnt + 8'd1;
                    if (cnt != 8'd0)
                        rbuf[{cap_idx, 3'b000} +: 8] <= mem_din;
                end
                WR:      cnt <= cnt + 8'd1;
                default: cnt <= 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: small synchronous byte RAM model plus cycle-exact
// checks of addresses, write strobes, ready pulses and extended data.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_read, ram_write, ram_signed;
    logic [31:0] ram_addr, ram_data_i;
    logic [2:0]  ram_length;
    logic        ram_ready;
    logic [31:0] ram_data_o;
    logic        if_read;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    logic [7:0]  ram [0:4095];
    int          nchk = 0;
    int          nerr = 0;

    mem_ctrl dut (
        .clk(clk), .reset(reset),
        .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_data_i(ram_data_i), .ram_length(ram_length), .ram_signed(ram_signed),
        .ram_ready(ram_ready), .ram_data_o(ram_data_o),
        .if_read(if_read), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    // Synchronous read: byte for the address driven in the previous cycle.
    always @(posedge clk) mem_din <= ram[mem_a[11:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [31:0] a, input logic [2:0] len, input logic s,
                            input logic [31:0] exp, input int n);
        ram_addr = a; ram_length = len; ram_signed = s; ram_read = 1'b1;
        for (int c = 0; c <= n + 3; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= n) begin
                chk("ld_addr", mem_a, a + 32'(c) - 32'd1);
                chk("ld_wr", {31'd0, mem_wr}, 32'd0);
            end
            if (c == n + 2) begin
                chk("ld_rdy", {31'd0, ram_ready}, 32'd1);
                chk("ld_data", ram_data_o, exp);
                ram_read = 1'b0;
            end else begin
                chk("ld_rdy_lo", {31'd0, ram_ready}, 32'd0);
            end
            chk("ld_if_rdy", {31'd0, if_ready}, 32'd0);
            nxt;
        end
    endtask

    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input int n);
        int hit302;
        hit302 = 0;
        ram_addr = a; ram_data_i = d; ram_length = 3'(n); ram_write = 1'b1;
        for (int c = 0; c <= n + 2; c++) begin
            @(negedge clk);
            if (mem_wr && mem_a == 32'h302) hit302++;
            if (c >= 1 && c <= n) begin
                chk("st_wr", {31'd0, mem_wr}, 32'd1);
                chk("st_addr", mem_a, a + 32'(c) - 32'd1);
                chk("st_byte", {24'd0, mem_dout}, (d >> (8 * (c - 1))) & 32'hFF);
            end else begin
                chk("st_wr_lo", {31'd0, mem_wr}, 32'd0);
            end
            if (c == n + 1) begin
                chk("st_rdy", {31'd0, ram_ready}, 32'd1);
                ram_write = 1'b0;
            end else begin
                chk("st_rdy_lo", {31'd0, ram_ready}, 32'd0);
            end
            nxt;
        end
        chk("st_untouched", 32'(hit302), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h200] = 8'h80; ram[12'h202] = 8'h34; ram[12'h203] = 8'hF2;
        ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hB2; ram[12'h000] = 8'hC3; ram[12'h001] = 8'hD4;
        reset = 1'b1; ram_read = 0; ram_write = 0; ram_signed = 0; if_read = 0;
        ram_addr = 0; ram_data_i = 0; ram_length = 0; if_addr = 0;
        repeat (2) nxt;
        @(negedge clk);
        chk("rst_a", mem_a, 32'd0);
        chk("rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_rdy", {30'd0, ram_ready, if_ready}, 32'd0);
        chk("rst_data", ram_data_o | if_data, 32'd0);
        nxt;
        reset = 1'b0;
        nxt;

        run_load(32'h100, 3'd4, 1'b0, 32'h44332211, 4);
        run_load(32'h200, 3'd1, 1'b1, 32'hFFFFFF80, 1);
        run_load(32'h200, 3'd1, 1'b0, 32'h00000080, 1);
        run_load(32'h202, 3'd2, 1'b1, 32'hFFFFF234, 2);
        run_load(32'h202, 3'd2, 1'b0, 32'h0000F234, 2);
        run_load(32'h100, 3'd3, 1'b1, 32'h44332211, 4);
        run_load(32'hFFFFFFFE, 3'd4, 1'b0, 32'hD4C3B2A1, 4);
        run_store(32'h300, 32'hDEADBEEF, 2);

        // Store and fetch raised together: store wins, fetch follows.
        ram_write = 1'b1; ram_addr = 32'h400; ram_data_i = 32'h12345678; ram_length = 3'd4;
        if_read = 1'b1; if_addr = 32'h100;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            chk("arb_wr", {31'd0, mem_wr}, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            chk("arb_rrdy", {31'd0, ram_ready}, (c == 5) ? 32'd1 : 32'd0);
            chk("arb_irdy", {31'd0, if_ready}, (c == 12) ? 32'd1 : 32'd0);
            if (c == 5) ram_write = 1'b0;
            if (c == 7) chk("arb_faddr", mem_a, 32'h100);
            if (c == 12) begin
                chk("arb_idata", if_data, 32'h44332211);
                if_read = 1'b0;
            end
            nxt;
        end

        // Fetch dropped in cycle 3 aborts without if_ready.
        if_read = 1'b1; if_addr = 32'h100;
        for (int c = 0; c <= 8; c++) begin
            if (c == 3) if_read = 1'b0;
            @(negedge clk);
            if (c == 2) chk("ab_addr", mem_a, 32'h101);
            if (c == 4) chk("ab_idle", mem_a, 32'd0);
            chk("ab_irdy", {31'd0, if_ready}, 32'd0);
            nxt;
        end

        // Reset in cycle 3 of a word load kills it.
        ram_read = 1'b1; ram_addr = 32'h100; ram_length = 3'd4; ram_signed = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            if (c == 3) reset = 1'b1;
            if (c == 4) begin
                reset = 1'b0;
                ram_read = 1'b0;
            end
            @(negedge clk);
            if (c == 4) begin
                chk("rml_a", mem_a, 32'd0);
                chk("rml_wr", {23'd0, mem_wr, mem_dout}, 32'd0);
                chk("rml_data", ram_data_o | if_data, 32'd0);
                chk("rml_irdy", {31'd0, if_ready}, 32'd0);
            end
            chk("rml_rdy", {31'd0, ram_ready}, 32'd0);
            nxt;
        end

        run_load(32'h100, 3'd4, 1'b0, 32'h44332211, 4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller sitting directly below the MEM stage and the IF stage: it accepts word/half/byte load and store requests from the MEM stage and word fetches from the IF stage, and sequences them onto a single 8-bit synchronous RAM port. It returns a one-cycle ready pulse with sign- or zero-extended read data, which releases the requesting stage's stall. Data-port requests have priority over fetches; an in-flight transaction is never preempted.

## Interface
- No parameters; address and data buses are 32 bits.
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- ram_read  in  1  MEM-stage load request; held until ram_ready
- ram_write  in  1  MEM-stage store request; held until ram_ready
- ram_addr  in  32  byte address of the first byte
- ram_data_i  in  32  store data; low `ram_length` bytes are used
- ram_length  in  3  access size in bytes: 1, 2 or 4
- ram_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- ram_ready  out  1  one-cycle completion pulse for the data port
- ram_data_o  out  32  extended load result; valid while ram_ready=1
- if_read  in  1  fetch request, always 4 bytes unsigned; may drop at any time
- if_addr  in  32  fetch byte address
- if_ready  out  1  one-cycle completion pulse for the fetch port
- if_data  out  32  fetched word; valid while if_ready=1
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write enable for this cycle's byte
- mem_dout  out  8  RAM write byte
- mem_din  in  8  RAM read byte for the address driven in the previous cycle

## Operation
- States: IDLE, RD, WR, DONE. An 8-bit byte counter `cnt` and a 32-bit assembly buffer are registered.
- IDLE: if ram_read=1, latch address, length and signed, then go to RD (data port). Else if ram_write=1, latch address, length and data, then go to WR. Else if if_read=1, latch if_addr with length 4, then go to RD (fetch port). Otherwise stay in IDLE.
- RD:
  - Cycle i (i=0..N-1) drives mem_a = addr+i with mem_wr=0.
  - The byte returned on mem_din in the following cycle is stored into buffer[8i+7:8i] (little-endian).
  - After capturing byte N-1, go to DONE.
- WR:
  - Cycle i drives mem_a = addr+i, mem_wr=1, mem_dout = data[8i+7:8i].
  - After byte N-1, go to DONE.
- DONE: pulse the ready output of the owning port for one cycle and drive the extended buffer on its data output, then return to IDLE. Requests are sampled only in IDLE, never in DONE, so a request still held during its own ready cycle is not restarted.
- Load extension:
  - Length 1: bits [31:8] = bit 7 if signed, otherwise 0.
  - Length 2: bits [31:16] = bit 15 if signed, otherwise 0.
  - Length 4: passed through unchanged.
- Lengths 0, 3 and 5-7 are illegal and are treated as 4.
- Fetch abort: if if_read=0 in any RD cycle of a fetch transaction, go to IDLE next cycle with no if_ready. Data-port requests never abort.
- Address arithmetic is modulo 2^32 (wraps at 0xFFFFFFFF).
- Output defaults whenever not driven as described above: mem_a=0, mem_wr=0, mem_dout=0, both ready outputs 0, both data outputs 0.
- Reset: state goes to IDLE and all registers and outputs return to 0. A store interrupted by reset may leave bytes partially written; this is accepted.

## Timing
- Cycle 0 is the first IDLE cycle in which the request is high.
- Load of N bytes:
  - Addresses are driven in cycles 1..N.
  - Bytes are captured at the ends of cycles 2..N+1.
  - ram_ready is high in cycle N+2.
  - A 4-byte load therefore stalls the MEM stage for 6 cycles, ready in the 7th.
- Store of N bytes: mem_wr is high in cycles 1..N; ram_ready is high in cycle N+1.
- Fetch: same timing as a 4-byte load; if_ready is high in cycle 6.
- Back-to-back transactions: the next request can be accepted no earlier than the cycle after DONE.
- Ready is never high on both ports in the same cycle. mem_wr is never high outside WR.

## Test plan
- Word load: RAM[0x100..0x103] = 11 22 33 44, ram_read, addr 0x100, length 4 -> ram_ready in cycle 6 only, with ram_data_o = 0x44332211.
- Signed and unsigned byte/half loads:
  - RAM[0x200] = 0x80, length 1, signed=1 -> 0xFFFFFF80; signed=0 -> 0x00000080.
  - RAM[0x202..0x203] = 34 F2, length 2, signed=1 -> 0xFFFFF234.
- Half store: addr 0x300, data 0xDEADBEEF, length 2 -> mem_wr in cycles 1-2 writing 0xEF to 0x300 and 0xBE to 0x301; 0x302 untouched; ram_ready in cycle 3.
- Arbitration: ram_write and if_read raised in the same cycle -> store served first. The fetch starts in the IDLE cycle after DONE, and if_ready arrives 6 cycles later.
- Fetch abort and wrap:
  - if_read dropped in cycle 3 -> no if_ready; IDLE in cycle 4.
  - Load length 4 at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
- Reset mid-load: reset asserted in cycle 3 of a word load -> the next cycle is IDLE with all outputs 0, and no ram_ready ever pulses for that load.
